// File: rtl/spm_dp_ctrl.sv
// Dual-port scratchpad controller: IF and MEM ports share one inferred RAM.
// Per-byte writes, write-first forwarding across ports, MEM lanes win on a
// same-address write/write collision, and a power-on clear sequencer zeroes
// the array after reset.
// Optional feature macro: SPM_PARITY_EN (one even-parity bit per byte lane).
module spm_dp_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [ADDR_W-1:0]   if_spm_addr,
    input  logic                if_spm_as_,
    input  logic                if_spm_rw,
    input  logic [DATA_W/8-1:0] if_spm_be,
    input  logic [DATA_W-1:0]   if_spm_wr_data,
    output logic [DATA_W-1:0]   if_spm_rd_data,
    output logic                if_spm_rd_vld,
    output logic                if_spm_par_err,
    input  logic [ADDR_W-1:0]   mem_spm_addr,
    input  logic                mem_spm_as_,
    input  logic                mem_spm_rw,
    input  logic [DATA_W/8-1:0] mem_spm_be,
    input  logic [DATA_W-1:0]   mem_spm_wr_data,
    output logic [DATA_W-1:0]   mem_spm_rd_data,
    output logic                mem_spm_rd_vld,
    output logic                mem_spm_par_err,
    output logic                spm_busy
);

    localparam int BL    = int'(DATA_W / 8);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef SPM_PARITY_EN
    logic [BL-1:0]     par_q [DEPTH];
    logic              if_rd_perr, mem_rd_perr;
    logic              if_par_err_q, mem_par_err_q;
`endif

    logic              if_re, if_we, mem_re, mem_we;
    logic [DATA_W-1:0] if_rd_word, mem_rd_word;

    assign spm_busy = (state_q == StClear);

    // Requests are only accepted once the clear sequence has finished.
    assign if_re  = !spm_busy && !if_spm_as_ && if_spm_rw;
    assign if_we  = !spm_busy && !if_spm_as_ && !if_spm_rw;
    assign mem_re = !spm_busy && !mem_spm_as_ && mem_spm_rw;
    assign mem_we = !spm_busy && !mem_spm_as_ && !mem_spm_rw;

    // FSM state and clear-address register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: walk every address once, then stay in service until reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = StReady;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StReady: ;
            default: state_d = StClear;
        endcase
    end

    // IF read word with write-first forwarding from a same-cycle MEM write.
    always_comb begin
        if_rd_word = mem_q[if_spm_addr];
`ifdef SPM_PARITY_EN
        if_rd_perr = 1'b0;
`endif
        for (int i = 0; i < BL; i++) begin
            if (mem_we && mem_spm_be[i] && (mem_spm_addr == if_spm_addr)) begin
                if_rd_word[8*i +: 8] = mem_spm_wr_data[8*i +: 8];
            end
`ifdef SPM_PARITY_EN
            // Forwarded lanes carry freshly computed parity, so only stored lanes can fail.
            else if (par_q[if_spm_addr][i] != ^mem_q[if_spm_addr][8*i +: 8]) begin
                if_rd_perr = 1'b1;
            end
`endif
        end
    end

    // MEM read word with write-first forwarding from a same-cycle IF write.
    always_comb begin
        mem_rd_word = mem_q[mem_spm_addr];
`ifdef SPM_PARITY_EN
        mem_rd_perr = 1'b0;
`endif
        for (int i = 0; i < BL; i++) begin
            if (if_we && if_spm_be[i] && (if_spm_addr == mem_spm_addr)) begin
                mem_rd_word[8*i +: 8] = if_spm_wr_data[8*i +: 8];
            end
`ifdef SPM_PARITY_EN
            else if (par_q[mem_spm_addr][i] != ^mem_q[mem_spm_addr][8*i +: 8]) begin
                mem_rd_perr = 1'b1;
            end
`endif
        end
    end

    // RAM array: clear writes during busy, otherwise per-byte port writes.
    // MEM is written after IF so its lanes win a same-address collision.
    always_ff @(posedge clk) begin
        if (spm_busy) begin
            mem_q[clr_addr_q] <= '0;
`ifdef SPM_PARITY_EN
            par_q[clr_addr_q] <= '0;
`endif
        end else begin
            for (int i = 0; i < BL; i++) begin
                if (if_we && if_spm_be[i]) begin
                    mem_q[if_spm_addr][8*i +: 8] <= if_spm_wr_data[8*i +: 8];
`ifdef SPM_PARITY_EN
                    par_q[if_spm_addr][i] <= ^if_spm_wr_data[8*i +: 8];
`endif
                end
            end
            for (int i = 0; i < BL; i++) begin
                if (mem_we && mem_spm_be[i]) begin
                    mem_q[mem_spm_addr][8*i +: 8] <= mem_spm_wr_data[8*i +: 8];
`ifdef SPM_PARITY_EN
                    par_q[mem_spm_addr][i] <= ^mem_spm_wr_data[8*i +: 8];
`endif
                end
            end
        end
    end

    // Read data/valid registers; rd_data holds until the next accepted read.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            if_spm_rd_data  <= '0;
            if_spm_rd_vld   <= 1'b0;
            mem_spm_rd_data <= '0;
            mem_spm_rd_vld  <= 1'b0;
        end else begin
            if_spm_rd_vld  <= if_re;
            mem_spm_rd_vld <= mem_re;
            if (if_re) begin
                if_spm_rd_data <= if_rd_word;
            end
            if (mem_re) begin
                mem_spm_rd_data <= mem_rd_word;
            end
        end
    end

`ifdef SPM_PARITY_EN
    // Parity error flags pulse together with rd_vld.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            if_par_err_q  <= 1'b0;
            mem_par_err_q <= 1'b0;
        end else begin
            if_par_err_q  <= if_re && if_rd_perr;
            mem_par_err_q <= mem_re && mem_rd_perr;
        end
    end

    assign if_spm_par_err  = if_par_err_q;
    assign mem_spm_par_err = mem_par_err_q;
`else
    assign if_spm_par_err  = 1'b0;
    assign mem_spm_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_spm_dp_ctrl.sv
// Self-checking bench for spm_dp_ctrl: clear timing, reset mid-clear,
// directed collision cases and randomized dual-port traffic against a
// word-array reference model.
module tb_spm_dp_ctrl;

    logic        clk = 1'b0;
    logic        reset_;
    logic [11:0] if_spm_addr, mem_spm_addr;
    logic        if_spm_as_, mem_spm_as_;
    logic        if_spm_rw, mem_spm_rw;
    logic [3:0]  if_spm_be, mem_spm_be;
    logic [31:0] if_spm_wr_data, mem_spm_wr_data;
    logic [31:0] if_spm_rd_data, mem_spm_rd_data;
    logic        if_spm_rd_vld, mem_spm_rd_vld;
    logic        if_spm_par_err, mem_spm_par_err;
    logic        spm_busy;

    int errs   = 0;
    int checks = 0;

    // Reference model: word contents, lanes with corrupted parity, held read data.
    logic [31:0] mdl [4096];
    logic [3:0]  bad [4096];
    logic [31:0] exp_if_data, exp_mem_data;

    always #5 clk = ~clk;

    spm_dp_ctrl dut (
        .clk             (clk),
        .reset_          (reset_),
        .if_spm_addr     (if_spm_addr),
        .if_spm_as_      (if_spm_as_),
        .if_spm_rw       (if_spm_rw),
        .if_spm_be       (if_spm_be),
        .if_spm_wr_data  (if_spm_wr_data),
        .if_spm_rd_data  (if_spm_rd_data),
        .if_spm_rd_vld   (if_spm_rd_vld),
        .if_spm_par_err  (if_spm_par_err),
        .mem_spm_addr    (mem_spm_addr),
        .mem_spm_as_     (mem_spm_as_),
        .mem_spm_rw      (mem_spm_rw),
        .mem_spm_be      (mem_spm_be),
        .mem_spm_wr_data (mem_spm_wr_data),
        .mem_spm_rd_data (mem_spm_rd_data),
        .mem_spm_rd_vld  (mem_spm_rd_vld),
        .mem_spm_par_err (mem_spm_par_err),
        .spm_busy        (spm_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read value seen by one port: old word, with enabled bytes of the other
    // port's same-cycle write to that address substituted.
    function automatic logic [31:0] fwd_word(input logic [31:0] old, input bit ow,
                                             input logic [3:0] obe, input logic [31:0] od);
        logic [31:0] v;
        v = old;
        for (int i = 0; i < 4; i++) begin
            if (ow && obe[i]) v[8*i +: 8] = od[8*i +: 8];
        end
        return v;
    endfunction

    // One cycle of traffic on both ports; checks outputs right after the edge.
    task automatic access(input bit ie, input bit irw, input logic [11:0] ia,
                          input logic [3:0] ibe, input logic [31:0] id,
                          input bit me, input bit mrw, input logic [11:0] ma,
                          input logic [3:0] mbe, input logic [31:0] md);
        bit          iw, mw, ivld, mvld, iperr, mperr;
        logic [3:0]  ifwd, mfwd;
        iw   = ie && !irw;
        mw   = me && !mrw;
        ivld = ie && irw;
        mvld = me && mrw;
        ifwd = (mw && ma == ia) ? mbe : 4'h0;
        mfwd = (iw && ia == ma) ? ibe : 4'h0;
        iperr = ivld && |(bad[ia] & ~ifwd);
        mperr = mvld && |(bad[ma] & ~mfwd);
        if (ivld) exp_if_data  = fwd_word(mdl[ia], mw && ma == ia, mbe, md);
        if (mvld) exp_mem_data = fwd_word(mdl[ma], iw && ia == ma, ibe, id);
        for (int i = 0; i < 4; i++) begin
            if (iw && ibe[i]) begin
                mdl[ia][8*i +: 8] = id[8*i +: 8];
                bad[ia][i]        = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mw && mbe[i]) begin
                mdl[ma][8*i +: 8] = md[8*i +: 8];
                bad[ma][i]        = 1'b0;
            end
        end
        if_spm_as_      = !ie;
        if_spm_rw       = irw;
        if_spm_addr     = ia;
        if_spm_be       = ibe;
        if_spm_wr_data  = id;
        mem_spm_as_     = !me;
        mem_spm_rw      = mrw;
        mem_spm_addr    = ma;
        mem_spm_be      = mbe;
        mem_spm_wr_data = md;
        @(posedge clk);
        #1;
        if_spm_as_  = 1'b1;
        mem_spm_as_ = 1'b1;
        check_val("if_vld",   {31'b0, if_spm_rd_vld},  {31'b0, ivld});
        check_val("if_data",  if_spm_rd_data,          exp_if_data);
        check_val("mem_vld",  {31'b0, mem_spm_rd_vld}, {31'b0, mvld});
        check_val("mem_data", mem_spm_rd_data,         exp_mem_data);
`ifdef SPM_PARITY_EN
        check_val("if_perr",  {31'b0, if_spm_par_err},  {31'b0, iperr});
        check_val("mem_perr", {31'b0, mem_spm_par_err}, {31'b0, mperr});
`else
        check_val("if_perr",  {31'b0, if_spm_par_err},  32'h0);
        check_val("mem_perr", {31'b0, mem_spm_par_err}, 32'h0);
`endif
    endtask

    initial begin
        int busy_cycles;
        reset_          = 1'b0;
        if_spm_as_      = 1'b1;
        if_spm_rw       = 1'b1;
        if_spm_addr     = '0;
        if_spm_be       = '0;
        if_spm_wr_data  = '0;
        mem_spm_as_     = 1'b1;
        mem_spm_rw      = 1'b1;
        mem_spm_addr    = '0;
        mem_spm_be      = '0;
        mem_spm_wr_data = '0;
        for (int a = 0; a < 4096; a++) begin
            mdl[a] = '0;
            bad[a] = '0;
        end
        exp_if_data  = '0;
        exp_mem_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy",     {31'b0, spm_busy},       32'h1);
        check_val("rst_if_vld",   {31'b0, if_spm_rd_vld},  32'h0);
        check_val("rst_if_data",  if_spm_rd_data,          32'h0);
        check_val("rst_mem_data", mem_spm_rd_data,         32'h0);

        // Release, let the clear reach address 100, then pulse reset for 2 cycles.
        @(negedge clk);
        reset_ = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        reset_ = 1'b0;
        check_val("midclr_busy", {31'b0, spm_busy}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;

        // Clear restarts from 0: busy must span 4096 cycles; IF read of 0 is dropped meanwhile.
        if_spm_as_  = 1'b0;
        if_spm_rw   = 1'b1;
        if_spm_addr = 12'h000;
        busy_cycles = 0;
        while (spm_busy === 1'b1 && busy_cycles < 5000) begin
            busy_cycles++;
            if (if_spm_rd_vld !== 1'b0) check_val("busy_no_vld", {31'b0, if_spm_rd_vld}, 32'h0);
            @(negedge clk);
        end
        check_val("busy_cycles", busy_cycles, 32'd4096);
        check_val("busy_drop", {31'b0, if_spm_rd_vld}, 32'h0);
        @(posedge clk);
        #1;
        if_spm_as_ = 1'b1;
        check_val("clr_rd_vld",  {31'b0, if_spm_rd_vld}, 32'h1);
        check_val("clr_rd_data", if_spm_rd_data,         32'h0);

        // Partial-byte overwrite.
        access(0, 1, 0, 0, 0,  1, 0, 12'h234, 4'b1111, 32'hDEADBEEF);
        access(0, 1, 0, 0, 0,  1, 0, 12'h234, 4'b0010, 32'h0000AA00);
        access(1, 1, 12'h234, 0, 0,  0, 1, 0, 0, 0);
        check_val("be_merge", if_spm_rd_data, 32'hDEADAAEF);

        // Same-cycle write/write: MEM lanes win where enabled.
        access(1, 0, 12'h010, 4'b1111, 32'h11111111,  1, 0, 12'h010, 4'b0101, 32'h22222222);
        access(0, 1, 0, 0, 0,  1, 1, 12'h010, 0, 0);
        check_val("ww_collide", mem_spm_rd_data, 32'h11221122);

        // Same-cycle read/write: enabled bytes forwarded, others old.
        access(1, 0, 12'h020, 4'b1111, 32'hCAFEF00D,  0, 1, 0, 0, 0);
        access(1, 1, 12'h020, 0, 0,  1, 0, 12'h020, 4'b1100, 32'h00000000);
        check_val("rw_forward", if_spm_rd_data, 32'h0000F00D);

        // be = 0 write is a no-op; write visible next cycle on the other port.
        access(1, 0, 12'h020, 4'b0000, 32'hFFFFFFFF,  0, 1, 0, 0, 0);
        access(0, 1, 0, 0, 0,  1, 1, 12'h020, 0, 0);
        check_val("be0_noop", mem_spm_rd_data, 32'h0000F00D);

`ifdef SPM_PARITY_EN
        // Corrupt one stored data bit behind the parity bit.
        access(1, 0, 12'h030, 4'b1111, 32'h12345678,  0, 1, 0, 0, 0);
        @(negedge clk);
        dut.mem_q[12'h030] = dut.mem_q[12'h030] ^ 32'h00000008;
        mdl[12'h030]       = mdl[12'h030] ^ 32'h00000008;
        bad[12'h030]       = 4'b0001;
        access(1, 1, 12'h030, 0, 0,  1, 1, 12'h010, 0, 0);
        check_val("perr_flag",  {31'b0, if_spm_par_err},  32'h1);
        check_val("perr_clean", {31'b0, mem_spm_par_err}, 32'h0);
`endif

        // Random dual-port traffic over a small address pool to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            logic [11:0] ia, ma;
            ia = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
            ma = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
            access(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ia,
                   4'($urandom), $urandom,
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ma,
                   4'($urandom), $urandom);
        end

        // Reset mid-access returns outputs to reset values asynchronously.
        if_spm_as_ = 1'b0;
        if_spm_rw  = 1'b1;
        #2;
        reset_ = 1'b0;
        #1;
        check_val("rst_async_busy", {31'b0, spm_busy},      32'h1);
        check_val("rst_async_data", if_spm_rd_data,         32'h0);
        check_val("rst_async_vld",  {31'b0, if_spm_rd_vld}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
